instruction_control: RTL

INSTRUCTION_CONTROL -- requirements
Module: instruction_control

---
 rtl/instruction_control_pkg.sv | 55 +++++
 rtl/instruction_decoder.sv | 50 +++++
 rtl/instruction_control.sv | 119 +++++++++++
 3 files changed

// File: rtl/instruction_control_pkg.sv
// -----------------------------------------------------------------------------
// instruction_control_pkg
// Purpose : Shared encodings for the instruction controller, the datapath and
//           the assembler: opcodes, accumulator/ALU source selects, ALU op
//           codes, FSM state encoding and the bundled decoder control word.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package instruction_control_pkg;

  localparam int OPC_WIDTH     = 5;
  localparam int OPERAND_WIDTH = 11;

  typedef enum logic [OPC_WIDTH-1:0] {
    OPC_HLT  = 5'b00000,
    OPC_STO  = 5'b00001,
    OPC_LD   = 5'b00010,
    OPC_LDI  = 5'b00011,
    OPC_ADD  = 5'b00100,
    OPC_ADDI = 5'b00101,
    OPC_SUB  = 5'b00110,
    OPC_SUBI = 5'b00111
  } opcode_e;

  // Accumulator source select
  localparam logic [1:0] SEL_A_RAM = 2'd0;
  localparam logic [1:0] SEL_A_IMM = 2'd1;
  localparam logic [1:0] SEL_A_ALU = 2'd2;

  // ALU B-operand source select
  localparam logic SEL_B_RAM = 1'b0;
  localparam logic SEL_B_IMM = 1'b1;

  // ALU operation
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // Control word produced by the decoder
  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       op;
    logic       wr_acc;
    logic       wr_ram;
    logic       rd_ram;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/instruction_decoder.sv
// -----------------------------------------------------------------------------
// instruction_decoder
// Purpose : Purely combinational opcode decoder. Produces the datapath
//           control word and flags HLT. Unassigned opcodes decode as NOP
//           (all-zero control word, not HLT).
// Ports   : i_opcode  - 5-bit opcode field of the current instruction
//           o_ctrl    - selects, ALU op and read/write strobes
//           o_is_hlt  - current instruction is HLT
// -----------------------------------------------------------------------------
module instruction_decoder
  import instruction_control_pkg::*;
(
  input  logic [OPC_WIDTH-1:0] i_opcode,
  output ctrl_t                o_ctrl,
  output logic                 o_is_hlt
);

  always_comb begin
    o_ctrl   = CTRL_NONE;
    o_is_hlt = 1'b0;
    case (i_opcode)
      OPC_HLT: o_is_hlt = 1'b1;
      OPC_STO: o_ctrl.wr_ram = 1'b1;
      OPC_LD: begin
        o_ctrl.rd_ram = 1'b1;
        o_ctrl.sel_a  = SEL_A_RAM;
        o_ctrl.wr_acc = 1'b1;
      end
      OPC_LDI: begin
        o_ctrl.sel_a  = SEL_A_IMM;
        o_ctrl.wr_acc = 1'b1;
      end
      OPC_ADD, OPC_SUB: begin
        o_ctrl.rd_ram = 1'b1;
        o_ctrl.sel_b  = SEL_B_RAM;
        o_ctrl.op     = (i_opcode == OPC_SUB) ? ALU_SUB : ALU_ADD;
        o_ctrl.sel_a  = SEL_A_ALU;
        o_ctrl.wr_acc = 1'b1;
      end
      OPC_ADDI, OPC_SUBI: begin
        o_ctrl.sel_b  = SEL_B_IMM;
        o_ctrl.op     = (i_opcode == OPC_SUBI) ? ALU_SUB : ALU_ADD;
        o_ctrl.sel_a  = SEL_A_ALU;
        o_ctrl.wr_acc = 1'b1;
      end
      default: ; // NOP
    endcase
  end

endmodule

// File: rtl/instruction_control.sv
// -----------------------------------------------------------------------------
// instruction_control
// Purpose : Sequencer for a single-accumulator machine. An IDLE/RUN/HALT FSM
//           steps the program counter one instruction per clock, decodes the
//           instruction combinationally and counts executed instructions
//           (saturating).
// Ports   : clk, rst_n      - clock, asynchronous active-low reset
//           start           - pulse: begin execution at PC 0 (IDLE or HALT)
//           instr_data      - program-memory read data
//           pc              - program-memory address (registered)
//           operand         - instr_data[10:0], data address / immediate
//           sel_a/sel_b/op  - datapath selects and ALU op
//           wr_acc/wr_ram/rd_ram - accumulator / RAM strobes
//           running/halted  - FSM status
//           cycle_count     - instructions executed since last start
// -----------------------------------------------------------------------------
module instruction_control
  import instruction_control_pkg::*;
#(
  parameter int PC_WIDTH    = 11,
  parameter int INSTR_WIDTH = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [INSTR_WIDTH-1:0] instr_data,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [10:0]            operand,
  output logic [1:0]             sel_a,
  output logic                   sel_b,
  output logic                   op,
  output logic                   wr_acc,
  output logic                   wr_ram,
  output logic                   rd_ram,
  output logic                   running,
  output logic                   halted,
  output logic [CNT_WIDTH-1:0]   cycle_count
);

  localparam logic [PC_WIDTH-1:0]  PC_ONE  = PC_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_e               r_state, w_state_next;
  logic [PC_WIDTH-1:0]  r_pc, w_pc_next;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_next;

  ctrl_t w_ctrl;
  ctrl_t w_ctrl_gated;
  logic  w_is_hlt;
  logic  w_run;

  instruction_decoder u_decoder (
    .i_opcode (instr_data[INSTR_WIDTH-1 -: OPC_WIDTH]),
    .o_ctrl   (w_ctrl),
    .o_is_hlt (w_is_hlt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_cnt_next   = r_cnt;
    case (r_state)
      // IDLE and HALT both restart from address 0 with a cleared count
      ST_IDLE, ST_HALT: begin
        if (start) begin
          w_state_next = ST_RUN;
          w_pc_next    = '0;
          w_cnt_next   = '0;
        end
      end
      ST_RUN: begin
        // HLT itself counts as an executed instruction
        w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
        if (w_is_hlt) begin
          w_state_next = ST_HALT;
        end else begin
          w_pc_next = r_pc + PC_ONE; // wraps naturally at 2**PC_WIDTH
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_pc_next    = '0;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign w_run        = (r_state == ST_RUN);
  // Reset forces r_state to IDLE asynchronously, so gating on RUN also
  // silences the strobes the instant rst_n falls.
  assign w_ctrl_gated = w_run ? w_ctrl : CTRL_NONE;

  assign pc          = r_pc;
  assign operand     = instr_data[10:0];
  assign sel_a       = w_ctrl_gated.sel_a;
  assign sel_b       = w_ctrl_gated.sel_b;
  assign op          = w_ctrl_gated.op;
  assign wr_acc      = w_ctrl_gated.wr_acc;
  assign wr_ram      = w_ctrl_gated.wr_ram;
  assign rd_ram      = w_ctrl_gated.rd_ram;
  assign running     = w_run;
  assign halted      = (r_state == ST_HALT);
  assign cycle_count = r_cnt;

endmodule
